// File: rtl/buffer_ctrl_pkg.sv
// Shared types and helpers for the convolution operand buffer sequencer.
package buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int SAT_CNT_W = 16;

    function automatic int calc_chunks(input int data_of_set, input int num_of_mul);
        return data_of_set / num_of_mul;
    endfunction

endpackage

// File: rtl/buffer_ctrl_sat_counter.sv
// Saturating event counter: synchronous clear wins over increment, holds at all-ones.
module sat_counter
    import buffer_pkg::*;
#(
    parameter int WIDTH = SAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Operand buffer sequencer: admits whole sets, drains NUM_OF_MUL-wide chunks, flags job done.
// Define BUFFER_CTRL_PERF_EN to add the stall/starve performance counters.
module buffer_ctrl
    import buffer_pkg::*;
#(
    parameter int DATA_OF_SET = 128,
    parameter int NUM_OF_MUL  = 16,
    parameter int NUM_OF_SET  = 1,
    parameter int CNT_WIDTH   = SAT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    output logic buf_wen,
    output logic buf_ren,
    input  logic buf_full,
    input  logic buf_empty,
    output logic mul_valid,
    input  logic mul_ready,
    output logic mul_last,
    output logic busy,
    output logic done
`ifdef BUFFER_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_in_cnt,
    output logic [CNT_WIDTH-1:0] stall_mul_cnt,
    output logic [CNT_WIDTH-1:0] starve_cnt
`endif
);

    localparam int CHUNKS  = calc_chunks(DATA_OF_SET, NUM_OF_MUL);
    localparam int CHUNK_W = $clog2(CHUNKS - 1) + 1;
    localparam int SET_W   = $clog2(NUM_OF_SET) + 1;

    if ((DATA_OF_SET % NUM_OF_MUL) != 0 || NUM_OF_SET < 1 || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("buffer_ctrl: illegal parameter combination");
    end

    state_e             state_q, state_d;
    logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [SET_W-1:0]   sets_wr_q, sets_wr_d;
    logic [SET_W-1:0]   sets_rd_q, sets_rd_d;
    logic               mul_valid_q, mul_valid_d;

    logic             start_acc;
    logic             mul_hs;
    logic             active;
    logic [SET_W-1:0] sets_wr_inc;

    assign active      = (state_q == RUN) || (state_q == DRAIN);
    assign start_acc   = (state_q == IDLE) && start;
    assign in_ready    = (state_q == RUN) && !buf_full;
    assign buf_wen     = in_valid && in_ready;
    assign buf_ren     = active && !buf_empty && (!mul_valid_q || mul_ready)
                         && (sets_rd_q < SET_W'(NUM_OF_SET));
    assign mul_valid   = mul_valid_q;
    assign mul_last    = mul_valid_q && (chunk_cnt_q == CHUNK_W'(CHUNKS - 1));
    assign mul_hs      = mul_valid_q && mul_ready;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign sets_wr_inc = sets_wr_q + SET_W'(1);

    always_comb begin
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        sets_wr_d   = sets_wr_q;
        sets_rd_d   = sets_rd_q;
        mul_valid_d = mul_valid_q;

        if (buf_wen) begin
            sets_wr_d = sets_wr_inc;
        end
        if (mul_hs) begin
            if (mul_last) begin
                chunk_cnt_d = '0;
                sets_rd_d   = sets_rd_q + SET_W'(1);
            end else begin
                chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
            end
        end
        // A fresh read refills the output register even as the current chunk leaves.
        if (buf_ren) begin
            mul_valid_d = 1'b1;
        end else if (mul_hs) begin
            mul_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    chunk_cnt_d = '0;
                    sets_wr_d   = '0;
                    sets_rd_d   = '0;
                    mul_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (buf_wen && (sets_wr_inc == SET_W'(NUM_OF_SET))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mul_hs && mul_last && (sets_rd_q == SET_W'(NUM_OF_SET - 1))) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chunk_cnt_q <= '0;
            sets_wr_q   <= '0;
            sets_rd_q   <= '0;
            mul_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            sets_wr_q   <= sets_wr_d;
            sets_rd_q   <= sets_rd_d;
            mul_valid_q <= mul_valid_d;
        end
    end

`ifdef BUFFER_CTRL_PERF_EN
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_in (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .inc ((state_q == RUN) && in_valid && buf_full),
        .cnt (stall_in_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_mul (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .inc (mul_valid_q && !mul_ready),
        .cnt (stall_mul_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .inc (active && buf_empty && !mul_valid_q),
        .cnt (starve_cnt)
    );
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl: vector table, directed corner sequences, randomized jobs.
module tb_buffer_ctrl;

    localparam int DOS   = 8;
    localparam int NOM   = 4;
    localparam int NOS   = 2;
    localparam int CW    = 16;
    localparam int CH    = DOS / NOM;
    localparam int TOTAL = CH * NOS;
    localparam int CAP   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic mul_ready = 1'b0;
    logic full_ovr = 1'b0;
    logic in_ready, buf_wen, buf_ren, buf_full, buf_empty;
    logic mul_valid, mul_last, busy, done;
`ifdef BUFFER_CTRL_PERF_EN
    logic [CW-1:0] stall_in_cnt, stall_mul_cnt, starve_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buffer_ctrl #(
        .DATA_OF_SET (DOS),
        .NUM_OF_MUL  (NOM),
        .NUM_OF_SET  (NOS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_wen   (buf_wen),
        .buf_ren   (buf_ren),
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_last  (mul_last),
        .busy      (busy),
        .done      (done)
`ifdef BUFFER_CTRL_PERF_EN
        ,
        .stall_in_cnt  (stall_in_cnt),
        .stall_mul_cnt (stall_mul_cnt),
        .starve_cnt    (starve_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural buffer: a FIFO of chunk ids, whole sets in, one chunk out per ren.
    int q[$];
    int wr_id = 0;
    int out_id = 0;
    int cnt = 0;
    assign buf_full  = full_ovr || (cnt + DOS > CAP);
    assign buf_empty = (cnt < NOM);

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cnt <= 0;
        end else begin
            if (buf_wen) begin
                for (int c = 0; c < CH; c++) begin
                    q.push_back(wr_id);
                    wr_id++;
                end
            end
            if (buf_ren && q.size() > 0) out_id <= q.pop_front();
            cnt <= cnt + (buf_wen ? DOS : 0) - (buf_ren ? NOM : 0);
        end
    end

    // Scoreboard: chunk order, last-chunk marking, write count and done timing.
    int exp_id = 0;
    int hs_job = 0;
    int wen_job = 0;
    bit done_pend = 1'b0;
    bit fin = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hs_job = 0;
            wen_job = 0;
            done_pend = 1'b0;
            exp_id = wr_id;
        end else begin
            fin = 1'b0;
            check("done_timing", int'(done), int'(done_pend));
            if (start && !busy) begin
                hs_job = 0;
                wen_job = 0;
            end
            if (buf_full) check("in_ready_when_full", int'(in_ready), 0);
            if (buf_wen) begin
                wen_job++;
                check("sets_not_exceeded", int'(wen_job <= NOS), 1);
            end
            if (buf_ren) begin
                check("ren_when_empty", int'(buf_empty), 0);
                check("ren_over_stalled_chunk", int'(mul_valid && !mul_ready), 0);
            end
            if (mul_valid && mul_ready) begin
                check("chunk_order", out_id, exp_id);
                check("mul_last_mark", int'(mul_last), int'((exp_id % CH) == CH - 1));
                exp_id++;
                fin = (hs_job == TOTAL - 1);
                hs_job++;
                if (fin) check("sets_written_at_end", wen_job, NOS);
            end
            done_pend = fin;
        end
    end

    typedef struct packed {
        logic       start;
        logic       in_valid;
        logic       mul_ready;
        logic [6:0] exp; // {in_ready, buf_wen, buf_ren, mul_valid, mul_last, busy, done}
    } vec_t;

    vec_t tbl[10];
    bit   wen_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int full_cyc, input int stall_cyc, input bit poke_start);
        bit got;
        start = 1'b1;
        in_valid = 1'b1;
        full_ovr = (full_cyc > 0);
        mul_ready = (stall_cyc == 0);
        tick();
        start = 1'b0;
        @(negedge clk);
`ifdef BUFFER_CTRL_PERF_EN
        check("perf_stall_in_cleared", int'(stall_in_cnt), 0);
        check("perf_stall_mul_cleared", int'(stall_mul_cnt), 0);
`endif
        for (int i = 0; i < full_cyc; i++) begin
            check("full_in_ready", int'(in_ready), 0);
            check("full_wen", int'(buf_wen), 0);
            tick();
            start = poke_start && (i == 0);
            if (i == full_cyc - 1) full_ovr = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (full_cyc > 0) check("full_release_accept", int'(buf_wen), 1);
        if (stall_cyc > 0) begin
            for (int t = 0; t < 30 && !mul_valid; t++) begin
                tick();
                @(negedge clk);
            end
            check("stall_first_valid", int'(mul_valid), 1);
            for (int k = 0; k < stall_cyc; k++) begin
                check("stall_valid_held", int'(mul_valid), 1);
                check("stall_no_ren", int'(buf_ren), 0);
                tick();
                if (k == stall_cyc - 1) mul_ready = 1'b1;
                @(negedge clk);
            end
        end
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
            @(negedge clk);
        end
        check("job_done_seen", int'(got), 1);
`ifdef BUFFER_CTRL_PERF_EN
        check("perf_stall_in", int'(stall_in_cnt), full_cyc);
        check("perf_stall_mul", int'(stall_mul_cnt), stall_cyc);
`endif
        tick();
        in_valid = 1'b0;
        mul_ready = 1'b1;
        check("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        bit got;
        int rst_at;

        tbl[0] = '{1'b0, 1'b0, 1'b1, 7'b0000000};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 7'b0000000};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 7'b1100010};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 7'b1110010};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 7'b0011010};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 7'b0011110};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 7'b0011010};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 7'b0001110};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 7'b0000011};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 7'b0000000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < 10; r++) begin
            start = tbl[r].start;
            in_valid = tbl[r].in_valid;
            mul_ready = tbl[r].mul_ready;
            @(negedge clk);
            check($sformatf("vec%0d", r),
                  int'({in_ready, buf_wen, buf_ren, mul_valid, mul_last, busy, done}),
                  int'(tbl[r].exp));
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;

        run_job(0, 3, 1'b0);
        run_job(5, 0, 1'b1);
        run_job(0, 0, 1'b0);

        // Reset while a chunk is waiting on the multiplier array.
        start = 1'b1;
        in_valid = 1'b1;
        mul_ready = 1'b0;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (mul_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("rst_seq_valid_before", int'(got), 1);
        check("rst_seq_busy_before", int'(busy), 1);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mul_ready = 1'b1;
        @(negedge clk);
        check("rst_mul_valid", int'(mul_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_mul_last", int'(mul_last), 0);
        check("rst_in_ready", int'(in_ready), 0);
        tick();
        run_job(0, 0, 1'b0);
        run_job(2, 3, 1'b0);

        for (int j = 0; j < 24; j++) begin
            rst_at = (j % 5 == 4) ? int'($urandom_range(3, 20)) : -1;
            start = 1'b1;
            in_valid = 1'b0;
            tick();
            start = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    break;
                end
                wen_seen = buf_wen;
                tick();
                if (c == rst_at) begin
                    rst = 1'b1;
                    start = 1'b0;
                    tick();
                    rst = 1'b0;
                    got = 1'b1;
                    break;
                end
                if (!(in_valid && !wen_seen)) in_valid = ($urandom_range(0, 3) != 0);
                mul_ready = ($urandom_range(0, 9) < 7);
                full_ovr = ($urandom_range(0, 9) < 2);
                start = ($urandom_range(0, 9) == 0);
            end
            check("rand_job_finished", int'(got), 1);
            if (!got) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            start = 1'b0;
            in_valid = 1'b0;
            full_ovr = 1'b0;
            mul_ready = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
